// File: rtl/plot_capture.sv
// Plot capture: buffers pixel plot requests in a small FIFO and writes them into a
// SCR_W x SCR_H x 3-bit framebuffer. The framebuffer can also be read back and wiped.
// One memory access per cycle, in priority order: wipe write, then read, then FIFO drain.
module plot_capture #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCR_W      = 160,
  parameter int unsigned SCR_H      = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic [2:0]  rd_data,
  output logic        rd_valid,
  input  logic        clear,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [15:0] plot_count
);

  localparam int unsigned NumPix = SCR_W * SCR_H;
  localparam int unsigned AddrW  = 15;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);

  localparam logic [AddrW-1:0] AddrOne  = AddrW'(1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(NumPix - 1);
  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]    CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW:0]    CntFull  = (PtrW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_t;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;

  plot_t            fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             fifo_full, fifo_empty;

  logic [2:0]       fb_mem [NumPix];
  logic [2:0]       mem_rdata_q;
  logic             rd_zero_q;
  logic             rd_valid_q;
  logic             overflow_q;
  logic [7:0]       drop_count_q;
  logic [15:0]      plot_count_q;

  logic             wipe_we, rd_go, pop, push, lost, drop;
  logic             plot_in_range, rd_in_range;
  plot_t            head;
  logic [AddrW-1:0] plot_addr, rd_addr;

  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];

  assign plot_in_range = (32'(vga_x) < SCR_W) && (32'(vga_y) < SCR_H);
  assign rd_in_range   = (32'(rd_x) < SCR_W) && (32'(rd_y) < SCR_H);
  assign plot_addr     = AddrW'(32'(head.y) * SCR_W + 32'(head.x));
  assign rd_addr       = AddrW'(32'(rd_y) * SCR_W + 32'(rd_x));

  // FSM state register and wipe address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // FSM next state: a wipe walks every address once and cannot be restarted
  always_comb begin
    state_d    = state_q;
    clr_addr_d = '0;
    unique case (state_q)
      StIdle: begin
        if (clear) state_d = StClear;
      end
      StClear: begin
        clr_addr_d = clr_addr_q + AddrOne;
        if (clr_addr_q == AddrLast) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: memory port arbitration
  always_comb begin
    busy    = 1'b0;
    wipe_we = 1'b0;
    rd_go   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        rd_go = rd_req;
        pop   = !rd_req && !fifo_empty;
      end
      StClear: begin
        busy    = 1'b1;
        wipe_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Plot request classification; a full FIFO still accepts when it pops on the same edge
  always_comb begin
    drop = vga_plot && !plot_in_range;
    push = vga_plot && plot_in_range && (!fifo_full || pop);
    lost = vga_plot && plot_in_range && fifo_full && !pop;
  end

  // FIFO pointers, occupancy and status counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      plot_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
      if (lost) overflow_q <= 1'b1;
      if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
      if (pop && (plot_count_q != 16'hFFFF)) plot_count_q <= plot_count_q + 16'd1;
    end
  end

  // FIFO storage, no reset needed: occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{x: vga_x, y: vga_y, colour: vga_colour};
  end

  // Framebuffer write/read port, left uninitialised by reset
  always_ff @(posedge clk) begin
    if (wipe_we) begin
      fb_mem[clr_addr_q] <= 3'b000;
    end else if (pop) begin
      fb_mem[plot_addr] <= head.colour;
    end
    if (rd_go && rd_in_range) mem_rdata_q <= fb_mem[rd_addr];
  end

  // Read response: rd_zero_q masks the raw memory data after reset and for off-screen reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) rd_zero_q <= !rd_in_range;
    end
  end

  assign rd_data    = rd_zero_q ? 3'b000 : mem_rdata_q;
  assign rd_valid   = rd_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign plot_count = plot_count_q;

endmodule

// File: tb/tb_plot_capture.sv
// Bench for plot_capture: directed scenarios plus random traffic, all compared against a
// queue-and-array reference model of the framebuffer, request FIFO and wipe.
module tb_plot_capture;

  localparam int NPIX  = 160 * 120;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic [7:0]  vga_x, rd_x;
  logic [6:0]  vga_y, rd_y;
  logic [2:0]  vga_colour, rd_data;
  logic        vga_plot, rd_req, rd_valid, clear, busy, overflow;
  logic [7:0]  drop_count;
  logic [15:0] plot_count;

  plot_capture dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear      (clear),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count),
    .plot_count (plot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  typedef struct {
    int         addr;
    logic [2:0] c;
  } ent_t;

  logic [2:0] fb [NPIX];
  bit         fb_known [NPIX];
  ent_t       q [$];
  bit         m_busy;
  int         m_waddr;
  bit         m_ovf;
  int         m_drop, m_plots;
  bit         e_valid, e_known;
  logic [2:0] e_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_waddr = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_plots = 0;
    e_valid = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later
  task automatic step(input bit p, input int px, input int py, input logic [2:0] pc,
                      input bit r, input int rx, input int ry, input bit cl, input bit chk);
    bit rd_ok, pop_m;
    ent_t e;
    vga_plot = p; vga_x = 8'(px); vga_y = 7'(py); vga_colour = pc;
    rd_req = r; rd_x = 8'(rx); rd_y = 7'(ry); clear = cl;
    @(posedge clk);
    rd_ok   = !m_busy && r;
    pop_m   = !m_busy && !r && (q.size() > 0);
    e_valid = rd_ok;
    if (rd_ok) begin
      if (rx < 160 && ry < 120) begin
        e_data  = fb[ry * 160 + rx];
        e_known = fb_known[ry * 160 + rx];
      end else begin
        e_data  = 3'b000;
        e_known = 1'b1;
      end
    end
    if (m_busy) begin
      fb[m_waddr]       = 3'b000;
      fb_known[m_waddr] = 1'b1;
      if (m_waddr == NPIX - 1) m_busy = 1'b0;
      else m_waddr++;
    end else if (cl) begin
      m_busy  = 1'b1;
      m_waddr = 0;
    end
    if (pop_m) begin
      e = q.pop_front();
      fb[e.addr]       = e.c;
      fb_known[e.addr] = 1'b1;
      if (m_plots < 65535) m_plots++;
    end
    if (p) begin
      if (px >= 160 || py >= 120) begin
        if (m_drop < 255) m_drop++;
      end else if (q.size() < DEPTH) begin
        e.addr = py * 160 + px;
        e.c    = pc;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    if (chk) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      check("plot_count", 32'(plot_count), 32'(m_plots));
      check("rd_valid", 32'(rd_valid), 32'(e_valid));
      if (e_valid && e_known) check("rd_data", 32'(rd_data), 32'(e_data));
    end
  endtask

  task automatic idle(input bit chk);
    step(0, 0, 0, 3'd0, 0, 0, 0, 0, chk);
  endtask

  int cnt;
  int px, py, rx, ry;

  initial begin
    rst = 1'b1;
    vga_plot = 0; vga_x = 0; vga_y = 0; vga_colour = 0;
    rd_req = 0; rd_x = 0; rd_y = 0; clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_plots", 32'(plot_count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Off-screen plots are dropped and never reach the FIFO
    step(1, 160, 0, 3'd5, 0, 0, 0, 0, 1);
    step(1, 0, 120, 3'd5, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
    check("oob_drop", 32'(drop_count), 32'd2);
    check("oob_plots", 32'(plot_count), 32'd0);

    // Plot then read back two cycles later
    step(1, 40, 78, 3'b010, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 3'd0, 1, 40, 78, 0, 1);
    check("rb_valid", 32'(rd_valid), 32'd1);
    check("rb_data", 32'(rd_data), 32'b010);
    check("rb_plots", 32'(plot_count), 32'd1);
    idle(1);
    check("rb_pulse", 32'(rd_valid), 32'd0);

    // Wipe: busy for exactly one cycle per pixel; plots accepted but held, reads ignored
    step(1, 40, 78, 3'b111, 0, 0, 0, 0, 1);
    idle(1);
    cnt = 0;
    step(0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
    if (busy) cnt++;
    for (int i = 0; i < 3; i++) begin
      step(1, $urandom_range(0, 39), $urandom_range(0, 119), 3'($urandom), 1, 40, 78, 1, 1);
      if (busy) cnt++;
    end
    for (int i = 0; i < 25000 && busy; i++) begin
      idle(0);
      if (busy) cnt++;
    end
    check("clr_len", 32'(cnt), 32'd19200);
    repeat (3) idle(1);
    check("clr_drained", 32'(plot_count), 32'd5);
    step(0, 0, 0, 3'd0, 1, 40, 78, 0, 1);
    check("clr_read", 32'(rd_data), 32'b000);

    // Plot and read of the same pixel on one edge: no bypass
    step(1, 10, 10, 3'b001, 1, 10, 10, 0, 1);
    check("nobyp_old", 32'(rd_data), 32'b000);
    idle(1);
    step(0, 0, 0, 3'd0, 1, 10, 10, 0, 1);
    check("nobyp_new", 32'(rd_data), 32'b001);

    // FIFO overflow while reads hold the memory port
    for (int i = 0; i < 6; i++) step(1, 41, 80, 3'd5, 1, 0, 0, 0, 1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_noplots", 32'(plot_count), 32'd6);
    repeat (4) idle(1);
    check("ovf_drained", 32'(plot_count), 32'd10);

    // Random traffic in a small window plus off-screen coordinates
    for (int i = 0; i < 1500; i++) begin
      px = ($urandom % 8 == 0) ? $urandom_range(160, 200) : $urandom_range(0, 7);
      py = ($urandom % 8 == 0) ? $urandom_range(120, 127) : $urandom_range(0, 7);
      rx = ($urandom % 10 == 0) ? $urandom_range(160, 255) : $urandom_range(0, 7);
      ry = $urandom_range(0, 7);
      step(($urandom % 3) != 0, px, py, 3'($urandom), ($urandom % 3) == 0, rx, ry, 0, 1);
    end
    repeat (6) idle(1);

    // Reset in the middle of a wipe
    step(0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 99; i++) idle(0);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_plots", 32'(plot_count), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 3'd0, 1, 0, 0, 0, 1);
    check("mid_addr0", 32'(rd_data), 32'd0);
    cnt = 0;
    step(0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
    if (busy) cnt++;
    for (int i = 0; i < 25000 && busy; i++) begin
      idle(0);
      if (busy) cnt++;
    end
    check("clr2_len", 32'(cnt), 32'd19200);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plot_capture.md
PLOT_CAPTURE -- requirements
Module: plot_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: plot request FIFO entries (power of two, >=2).
REQ-002 Parameter SCR_W, default 160: screen width in pixels.
REQ-003 Parameter SCR_H, default 120: screen height in pixels.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 vga_x  input  8  plot x coordinate.
REQ-007 vga_y  input  7  plot y coordinate.
REQ-008 vga_colour  input  3  plot colour.
REQ-009 vga_plot  input  1  plot strobe; one request per cycle while high.
REQ-010 rd_req  input  1  framebuffer read request.
REQ-011 rd_x  input  8  read x coordinate.
REQ-012 rd_y  input  7  read y coordinate.
REQ-013 rd_data  output  3  read colour.
REQ-014 rd_valid  output  1  rd_data valid strobe.
REQ-015 clear  input  1  start a framebuffer wipe to colour 0.
REQ-016 busy  output  1  high while a wipe is in progress.
REQ-017 overflow  output  1  sticky: a plot was lost to a full FIFO.
REQ-018 drop_count  output  8  saturating count of out-of-range plots.
REQ-019 plot_count  output  16  saturating count of plots written to memory.

Function
REQ-020 Framebuffer: SCR_W*SCR_H entries x 3 bits, single access per cycle, address = y*SCR_W + x (15 bits).
REQ-021 On an edge with vga_plot=1: x>=SCR_W or y>=SCR_H -> request discarded, drop_count +1 (saturating at 255), FIFO untouched.
REQ-022 In-range plot is pushed if FIFO not full, or if full with a pop on the same edge; otherwise it is lost and overflow set to 1 until reset.
REQ-023 Memory arbitration per cycle, in priority order: wipe write (state CLEAR), then read (rd_req=1), then FIFO pop-and-write.
REQ-024 Pop writes the head entry to memory on the same edge and increments plot_count (saturating at 65535); minimum plot-to-memory latency is 1 cycle (sampled edge N, written edge N+1).
REQ-025 FIFO order is preserved; a later plot to the same pixel overwrites an earlier one.
REQ-026 Read: rd_req sampled at edge N -> rd_data and rd_valid=1 during cycle N+1; rd_valid is a one-cycle pulse per request; back-to-back requests give back-to-back results.
REQ-027 Out-of-range read coordinates -> rd_valid=1 with rd_data=0.
REQ-028 A read returns memory contents only; plots still in the FIFO are not visible (no bypass).
REQ-029 States IDLE and CLEAR; IDLE->CLEAR when clear=1; CLEAR writes 0 to addresses 0..SCR_W*SCR_H-1, one per cycle; CLEAR->IDLE after the final address.
REQ-030 busy=1 exactly during CLEAR, i.e. SCR_W*SCR_H cycles (19200 by default).
REQ-031 clear asserted while in CLEAR is ignored; there is no restart.
REQ-032 During CLEAR: rd_req ignored (rd_valid stays 0); plots still pushed and counted per REQ-021/022; FIFO does not drain until IDLE.
REQ-033 Simultaneous clear and rd_req in IDLE: read serviced that cycle, CLEAR entered on the same edge.

Reset
REQ-034 rst=1 immediately forces: state IDLE, FIFO empty, busy=0, overflow=0, drop_count=0, plot_count=0, rd_valid=0, rd_data=0.
REQ-035 Reset does not initialise framebuffer contents; reset mid-CLEAR abandons the wipe, and written addresses keep 0.

Verification
REQ-036 Plot (40,78) colour 3'b010, then rd_req (40,78) two cycles later -> rd_valid=1 next cycle, rd_data=3'b010, plot_count=1.
REQ-037 vga_plot high 6 cycles at (41,80) with rd_req held high -> 4 pushed, overflow=1; release rd_req -> plot_count reaches 4 within 4 cycles.
REQ-038 Plot (160,0) and (0,120) -> drop_count=2, plot_count=0, no memory change.
REQ-039 Plot (40,78)=3'b111, pulse clear -> busy high exactly 19200 cycles; afterwards read (40,78) -> 3'b000.
REQ-040 rst pulsed at cycle 100 of CLEAR -> busy=0 immediately, all counters 0; address 0 reads 0; a new clear runs the full 19200 cycles.
REQ-041 Plot (10,10)=3'b001 and rd_req (10,10) on the same edge, previous value 0 -> rd_data=0; a re-read one cycle later -> 3'b001.
